// File: rtl/block_alloc_arbiter.sv
// rtl/block_alloc_arbiter.sv - free-cell pool FIFO with round-robin allocation grants
module block_alloc_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int NUM_BLOCKS = 64,
   parameter int ADDR_W     = 12,
   parameter int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] alloc_req,
   output logic [NUM_PORTS-1:0] alloc_gnt,
   output logic [ADDR_W-1:0]    alloc_idx,
   input  logic                 free_valid,
   input  logic [ADDR_W-1:0]    free_idx,
   output logic                 free_ready,
   output logic                 init_done,
   output logic [CNT_W-1:0]     free_count,
   output logic                 err
);

   localparam int PTR_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam int RR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_BLOCKS - 1);
   localparam logic [RR_W-1:0]  LAST_PORT = RR_W'(NUM_PORTS - 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                 state;
   logic [ADDR_W-1:0]      fifo [NUM_BLOCKS];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [RR_W-1:0]        rr_ptr;

   logic                   found;
   logic [RR_W-1:0]        winner;
   logic [RR_W-1:0]        cand;
   logic [RR_W:0]          sum;
   logic                   gnt_any;
   logic                   free_fire;
   logic                   idx_ok;
   logic                   pool_full;
   logic                   free_ok;
   logic                   free_bad;

   // Pool pointers wrap at the last cell, which need not be a power of two
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Round-robin scan starting at rr_ptr; only grants when a cell is in the pool
   always_comb begin
      found     = 1'b0;
      winner    = '0;
      cand      = '0;
      sum       = '0;
      alloc_gnt = '0;
      if (init_done && (free_count != '0)) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            sum = {1'b0, rr_ptr} + (RR_W+1)'(i);
            if (sum >= (RR_W+1)'(NUM_PORTS)) begin
               sum = sum - (RR_W+1)'(NUM_PORTS);
            end
            cand = sum[RR_W-1:0];
            if (!found && alloc_req[cand]) begin
               found  = 1'b1;
               winner = cand;
            end
         end
      end
      if (found) begin
         alloc_gnt[winner] = 1'b1;
      end
   end

   assign gnt_any    = found;
   assign alloc_idx  = fifo[rd_ptr];
   assign free_ready = init_done;
   assign free_fire  = free_valid & free_ready;
   assign idx_ok     = ({1'b0, free_idx} < (ADDR_W+1)'(NUM_BLOCKS));
   assign pool_full  = (free_count == CNT_W'(NUM_BLOCKS));
   assign free_ok    = free_fire & idx_ok & ~pool_full;
   assign free_bad   = free_fire & ~free_ok;

   // Pool fill during INIT, then grant/free bookkeeping in RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_INIT;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         rr_ptr     <= '0;
         free_count <= '0;
         init_done  <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               fifo[wr_ptr] <= ADDR_W'(wr_ptr);
               wr_ptr       <= ptr_inc(wr_ptr);
               free_count   <= free_count + 1'b1;
               if (wr_ptr == LAST_PTR) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               init_done <= 1'b1;
               if (gnt_any) begin
                  rd_ptr <= ptr_inc(rd_ptr);
                  rr_ptr <= (winner == LAST_PORT) ? '0 : winner + 1'b1;
               end
               if (free_ok) begin
                  fifo[wr_ptr] <= free_idx;
                  wr_ptr       <= ptr_inc(wr_ptr);
               end
               if (free_bad) begin
                  err <= 1'b1;
               end
               case ({gnt_any, free_ok})
                  2'b10:   free_count <= free_count - 1'b1;
                  2'b01:   free_count <= free_count + 1'b1;
                  default: free_count <= free_count;
               endcase
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_block_alloc_arbiter.sv
// tb/tb_block_alloc_arbiter.sv - scoreboard bench for block_alloc_arbiter
module tb_block_alloc_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  alloc_req = '0;
   logic [3:0]  alloc_gnt;
   logic [11:0] alloc_idx;
   logic        free_valid = 1'b0;
   logic [11:0] free_idx = '0;
   logic        free_ready;
   logic        init_done;
   logic [6:0]  free_count;
   logic        err;

   int n_cmp = 0;
   int n_mis = 0;
   int exp_port[$];
   int exp_idx[$];
   int mon_p;
   int mon_i;
   int n;

   block_alloc_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .alloc_req  (alloc_req),
      .alloc_gnt  (alloc_gnt),
      .alloc_idx  (alloc_idx),
      .free_valid (free_valid),
      .free_idx   (free_idx),
      .free_ready (free_ready),
      .init_done  (init_done),
      .free_count (free_count),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Monitor: every grant seen mid-cycle must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && alloc_gnt !== 4'b0) begin
         n_cmp++;
         if (exp_port.size() == 0) begin
            n_mis++;
            $display("FAIL grant_unexpected: got gnt=%b idx=%0d, none expected", alloc_gnt, alloc_idx);
         end else begin
            mon_p = exp_port.pop_front();
            mon_i = exp_idx.pop_front();
            if (alloc_gnt !== 4'(1 << mon_p) || alloc_idx !== 12'(mon_i)) begin
               n_mis++;
               $display("FAIL grant: got gnt=%b idx=%0d, expected port %0d idx %0d",
                        alloc_gnt, alloc_idx, mon_p, mon_i);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int p, input int ix);
      exp_port.push_back(p);
      exp_idx.push_back(ix);
   endtask

   task automatic do_free(input int ix);
      free_valid = 1'b1;
      free_idx   = 12'(ix);
      cyc();
      free_valid = 1'b0;
   endtask

   task automatic wait_init(output int cnt);
      cnt = 0;
      do begin
         cyc();
         cnt++;
      end while (!init_done && cnt < 200);
   endtask

   initial begin
      // Reset state
      repeat (3) cyc();
      chk("rst_gnt", int'(alloc_gnt), 0);
      chk("rst_init_done", int'(init_done), 0);
      chk("rst_free_ready", int'(free_ready), 0);
      chk("rst_free_count", int'(free_count), 0);
      chk("rst_err", int'(err), 0);

      // Init latency and full pool
      rst = 1'b0;
      wait_init(n);
      chk("init_latency", n, 65);
      chk("init_free_count", int'(free_count), 64);
      chk("init_err", int'(err), 0);
      chk("init_free_ready", int'(free_ready), 1);

      // All ports requesting: rotation 0..3, indices 0..63, then pool empty
      alloc_req = 4'hF;
      for (int i = 0; i < 64; i++) begin
         push(i % 4, i);
         cyc();
      end
      chk("drain_free_count", int'(free_count), 0);
      chk("drain_gnt_zero", int'(alloc_gnt), 0);
      repeat (3) cyc();
      chk("empty_gnt_zero", int'(alloc_gnt), 0);
      chk("empty_free_count", int'(free_count), 0);

      // Empty pool: free 17 with port 2 waiting, no bypass, grant next cycle
      alloc_req  = 4'b0100;
      free_valid = 1'b1;
      free_idx   = 12'd17;
      cyc();
      free_valid = 1'b0;
      chk("nobypass_count", int'(free_count), 1);
      push(2, 17);
      cyc();
      alloc_req = '0;
      chk("nobypass_after", int'(free_count), 0);

      // Build pool of 10 (40..49), then simultaneous grant + free(5)
      for (int k = 0; k < 10; k++) do_free(40 + k);
      chk("pool10", int'(free_count), 10);
      alloc_req  = 4'b0001;
      free_valid = 1'b1;
      free_idx   = 12'd5;
      push(0, 40);
      cyc();
      free_valid = 1'b0;
      alloc_req  = '0;
      chk("simul_count", int'(free_count), 10);
      alloc_req = 4'b0010;
      for (int k = 41; k < 50; k++) begin
         push(1, k);
         cyc();
      end
      push(1, 5);
      cyc();
      alloc_req = '0;
      chk("tail5_count", int'(free_count), 0);

      // Illegal free into a full pool
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      wait_init(n);
      chk("init_latency2", n, 65);
      do_free(3);
      chk("full_err", int'(err), 1);
      chk("full_count", int'(free_count), 64);

      // Out-of-range index after a fresh reset
      rst = 1'b1;
      cyc();
      chk("err_cleared", int'(err), 0);
      rst = 1'b0;
      wait_init(n);
      alloc_req = 4'b0001;
      push(0, 0);
      cyc();
      alloc_req = '0;
      chk("one_granted", int'(free_count), 63);
      do_free(70);
      chk("range_err", int'(err), 1);
      chk("range_count", int'(free_count), 63);

      // Reset in the middle of INIT restarts the fill
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (30) cyc();
      chk("mid_init_done", int'(init_done), 0);
      chk("mid_init_count", int'(free_count), 30);
      rst = 1'b1;
      cyc();
      chk("mid_rst_count", int'(free_count), 0);
      rst = 1'b0;
      wait_init(n);
      chk("init_latency3", n, 65);
      chk("refill_count", int'(free_count), 64);
      alloc_req = 4'hF;
      push(0, 0);
      cyc();
      push(1, 1);
      cyc();
      alloc_req = '0;
      chk("refill_after", int'(free_count), 62);

      cyc();
      chk("scoreboard_empty", exp_port.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/block_alloc_arbiter.md
Name: block_alloc_arbiter

Overview:
- Free-list manager and allocation arbiter for the shared packet cell memory: NUM_BLOCKS cells of BLOCK_BYTES each, linked through the 16-bit footer (next_idx, eop).
- Holds the pool of free cell indices in an internal circular FIFO.
- Grants one cell per cycle to NUM_PORTS ingress writers using round-robin arbitration.
- Accepts freed cell indices from the egress side, one per cycle.

Parameters:
- NUM_PORTS, 4, number of allocation requesters.
- NUM_BLOCKS, 64, number of cells in the pool; must be at most 2**ADDR_W.
- ADDR_W, 12, cell index width; matches footer next_idx.
- CNT_W, $clog2(NUM_BLOCKS+1), width of free_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- alloc_req  in  NUM_PORTS  per-port cell request; level, held until granted.
- alloc_gnt  out  NUM_PORTS  one-hot grant; combinational from req and state.
- alloc_idx  out  ADDR_W  granted cell index; valid when alloc_gnt is nonzero.
- free_valid  in  1  free request.
- free_idx  in  ADDR_W  cell index being returned.
- free_ready  out  1  free accepted; equals init_done.
- init_done  out  1  pool populated; allocation enabled.
- free_count  out  CNT_W  number of cells currently in the pool.
- err  out  1  sticky illegal-free flag.

Behaviour:
- Reset is synchronous, active-high, and clears all state. Reset values:
  - alloc_gnt=0, init_done=0, free_ready=0, free_count=0, err=0.
  - rd_ptr=0, wr_ptr=0, rr_ptr=0.
  - FSM enters INIT.
- FSM state INIT:
  - An init counter writes index k into FIFO slot k, one per cycle, for k=0..NUM_BLOCKS-1.
  - free_count increments each cycle.
  - After NUM_BLOCKS cycles the FSM enters RUN. init_done rises in the cycle after the last write, so init_done is first seen high NUM_BLOCKS+1 cycles after rst deasserts.
  - In INIT, alloc_gnt=0 and free_valid is ignored.
- FSM state RUN:
  - Stays in RUN until rst.
- Grant rules:
  - A grant is issued only in RUN with free_count>0.
  - The winner is the first requesting port found scanning from rr_ptr upward, wrapping modulo NUM_PORTS.
  - alloc_idx = FIFO[rd_ptr]. At the clock edge, rd_ptr advances and rr_ptr becomes (winner+1) mod NUM_PORTS.
  - With no request, or free_count==0, alloc_gnt=0 and no pointer moves. alloc_idx is don't-care; it is driven with FIFO[rd_ptr].
  - alloc_idx must not show X after init.
- Free rules:
  - A free is accepted on free_valid & free_ready.
  - An accepted free writes FIFO[wr_ptr]=free_idx and advances wr_ptr.
- Illegal free:
  - Illegal when free_count==NUM_BLOCKS or free_idx>=NUM_BLOCKS.
  - The illegal free is dropped: no write, no pointer move.
  - err is set and held until rst.
- Pointers wrap from NUM_BLOCKS-1 to 0. NUM_BLOCKS need not be a power of 2.
- Simultaneous grant and legal free in one cycle: both take effect and free_count is unchanged.
  - With free_count==0 there is no bypass: no grant that cycle, and the freed index is granted no earlier than the next cycle.
- free_count update:
  - Grant only: -1. Legal free only: +1.
  - free_count never underflows and never exceeds NUM_BLOCKS.
- Latency: request to grant is 0 cycles when a cell is available. A freed cell is allocatable 1 cycle after acceptance.
- Cell ownership:
  - The block never inspects footers.
  - Egress frees each cell of a packet individually while walking next_idx until eop.
- rst asserted mid-operation, including mid-INIT: the pool is discarded and INIT restarts from index 0.

Test Plan:
- Reset, idle -> init_done rises exactly 65 cycles after rst falls; free_count=64; err=0.
- All 4 ports hold req continuously, no frees -> grants rotate 0,1,2,3,0,...; alloc_idx = 0,1,2,...,63; after 64 grants free_count=0 and alloc_gnt stays 0.
- Pool empty, port 2 requesting; free idx 17 in cycle t -> no grant in t; grant to port 2 with alloc_idx=17 in t+1; free_count returns to 0.
- free_count=10, grant and free(idx 5) in the same cycle -> free_count stays 10; 5 is appended at the FIFO tail.
- Full pool, free idx 3 -> dropped, err=1, free_count=64. Then free idx 70 after rst -> err=1.
- rst pulsed at cycle 30 of INIT -> init_done stays 0; refill restarts at index 0; init_done rises 65 cycles after the second rst release.
